fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch/decode sequencer for the single-core datapath. Sequences each instruction fetch: PC onto the bus into AR, a memory read with a variable-latency ready handshake, and the memory word into IR with a PC increment. It then decodes the IR opcode and hands off to the execute controller. It also detects HALT, illegal opcodes and memory timeouts, and counts retired instructions.

## Interface

Parameters:
- N, 17, instruction word width (IR splits it into a 12-bit operand and a 5-bit opcode, zero-extended to 6 bits)
- MEM_TIMEOUT, 15, maximum cycles mem_rd may stay high without mem_ready
- HALT_OP, 6'h1F, opcode that stops the core

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin or resume fetching; sampled only in IDLE
- mem_ready  in  1  memory read data valid on the bus; sampled only in FETCH_MEM
- opcode  in  6  IR instruction output
- exec_done  in  1  execute controller finished the current instruction; sampled only in EXEC
- bus_sel  out  3  bus source: 0 none, 1 PC, 2 MEM
- ar_write_en  out  1  AR load
- mem_rd  out  1  memory read request
- ir_write_en  out  1  IR load
- pc_inc_en  out  1  PC increment
- dec_valid  out  1  one-cycle pulse: dec_opcode is valid and execution begins
- dec_opcode  out  6  registered opcode of the current instruction
- halted  out  1  HALT executed; core is idle
- fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 memory timeout, 2 illegal opcode
- instr_count  out  16  retired instruction count, wraps at 16'hFFFF -> 0
- state  out  3  current state, for debug

## Operation

State encoding: IDLE=0, FETCH_AR=1, FETCH_MEM=2, FETCH_IR=3, DECODE=4, EXEC=5, FAULT=7.

State behaviour and transitions:
- IDLE: all strobes low. If start=1: clear halted, go to FETCH_AR.
- FETCH_AR: bus_sel=1, ar_write_en=1 for exactly one cycle -> FETCH_MEM.
- FETCH_MEM: mem_rd=1.
  - Timeout counter cleared on entry; increments each cycle mem_ready=0.
  - mem_ready=1 -> FETCH_IR.
  - Counter = MEM_TIMEOUT-1 with mem_ready=0 -> FAULT, fault_code=1.
  - mem_ready wins when it coincides with the timeout cycle.
- FETCH_IR: bus_sel=2, ir_write_en=1, pc_inc_en=1 for one cycle -> DECODE.
- DECODE: opcode is stable (IR loaded at the end of FETCH_IR). Latch opcode into dec_opcode, then by priority:
  - opcode[5]=1 -> FAULT, fault_code=2.
  - opcode=HALT_OP -> halted=1, instr_count+1, go to IDLE, no dec_valid.
  - Otherwise dec_valid=1 and go to EXEC.
- EXEC: wait for exec_done=1, then instr_count+1 and go to FETCH_AR.
- FAULT: all strobes low. fault holds; start is ignored. Only rst exits.

Output decoding:
- Strobes (bus_sel, ar_write_en, mem_rd, ir_write_en, pc_inc_en, dec_valid) are Moore-decoded from the state register, plus the DECODE condition for dec_valid.
- Never more than one bus_sel source is active.

Ignored inputs:
- start outside IDLE.
- mem_ready outside FETCH_MEM.
- exec_done outside EXEC.

## Timing

- Reset: state=IDLE. Every output is 0: bus_sel, all strobes, dec_opcode, halted, fault, fault_code, instr_count, state.
- rst mid-operation, in any state, returns to IDLE on the next edge and overrides all other inputs. No strobe is asserted in the cycle after rst.
- Minimum instruction period is 5 cycles: FETCH_AR, FETCH_MEM (mem_ready in the first cycle), FETCH_IR, DECODE, EXEC (exec_done in the first EXEC cycle).
- mem_rd stays high for k+1 cycles when mem_ready arrives k cycles late. Its maximum is MEM_TIMEOUT cycles.
- dec_valid is high for exactly one cycle per non-HALT legal instruction. exec_done is never accepted in that same cycle.
- instr_count updates on the edge leaving EXEC (or DECODE for HALT) and is visible the following cycle.

## Test plan

- Reset: hold rst for 2 cycles with random inputs -> every output is 0 and state=0. Assert rst mid-EXEC -> next cycle state=0, instr_count retains its value?? No: reset clears it to 0.
- Basic fetch: start=1, mem_ready=1 immediately, opcode=6'h05, exec_done on the first EXEC cycle.
  - Required state sequence: 1, 2, 3, 4, 5, then back to 1.
  - dec_opcode=6'h05, dec_valid pulses once, instr_count=1.
- Wait states: mem_ready delayed 3 cycles -> mem_rd high for 4 consecutive cycles, and ir_write_en plus pc_inc_en are high together for exactly 1 cycle after them.
- Timeout: mem_ready held 0 with MEM_TIMEOUT=15.
  - Required: mem_rd high for 15 cycles, then state=7, fault=1, fault_code=1.
  - start pulses are then ignored until rst.
- HALT: opcode=6'h1F -> no dec_valid, halted=1, state=0, instr_count increments. A later start=1 clears halted and state becomes 1.
- Illegal opcode: opcode=6'h20 -> state=7, fault_code=2, no dec_valid. mem_ready=1 and exec_done=1 in FAULT produce no strobes.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch/decode sequencer: PC->AR, variable-latency memory read, IR load,
// opcode decode and handoff to execute, with HALT/fault detection.
module fetch_ctrl #(
  parameter int         N           = 17,
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [5:0] HALT_OP     = 6'h1F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [5:0]  opcode,
  input  logic        exec_done,
  output logic [2:0]  bus_sel,
  output logic        ar_write_en,
  output logic        mem_rd,
  output logic        ir_write_en,
  output logic        pc_inc_en,
  output logic        dec_valid,
  output logic [5:0]  dec_opcode,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] instr_count,
  output logic [2:0]  state
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_AR  = 3'd1,
    FETCH_MEM = 3'd2,
    FETCH_IR  = 3'd3,
    DECODE    = 3'd4,
    EXEC      = 3'd5,
    FAULT     = 3'd7
  } st_t;

  st_t           st, nxt;
  logic [CW-1:0] cnt;
  logic          illegal;
  logic          is_halt;
  logic          tmo;

  // Legal opcodes fit in the N-12 bits left after the operand field
  assign illegal = (opcode >> (N - 12)) != 6'd0;
  assign is_halt = opcode == HALT_OP;
  assign tmo     = cnt == CW'(MEM_TIMEOUT - 1);
  assign state   = st;

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else     st <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dec_opcode  <= '0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'd0;
      instr_count <= '0;
    end else begin
      // Counter is zero whenever FETCH_MEM is entered
      if (st == FETCH_MEM && !mem_ready) cnt <= cnt + 1'b1;
      else                               cnt <= '0;
      if (st == IDLE && start) halted <= 1'b0;
      if (st == DECODE) begin
        dec_opcode <= opcode;
        if (!illegal && is_halt) begin
          halted      <= 1'b1;
          instr_count <= instr_count + 16'd1;
        end
      end
      if (st == EXEC && exec_done) instr_count <= instr_count + 16'd1;
      if (nxt == FAULT && st != FAULT) begin
        fault      <= 1'b1;
        fault_code <= (st == FETCH_MEM) ? 2'd1 : 2'd2;
      end
    end
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:      if (start) nxt = FETCH_AR;
      FETCH_AR:  nxt = FETCH_MEM;
      FETCH_MEM: begin
        if (mem_ready) nxt = FETCH_IR;
        else if (tmo)  nxt = FAULT;
      end
      FETCH_IR:  nxt = DECODE;
      DECODE: begin
        if (illegal)      nxt = FAULT;
        else if (is_halt) nxt = IDLE;
        else              nxt = EXEC;
      end
      EXEC:      if (exec_done) nxt = FETCH_AR;
      FAULT:     nxt = FAULT;
      default:   nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_sel     = 3'd0;
    ar_write_en = 1'b0;
    mem_rd      = 1'b0;
    ir_write_en = 1'b0;
    pc_inc_en   = 1'b0;
    dec_valid   = 1'b0;
    unique case (st)
      FETCH_AR: begin
        bus_sel     = 3'd1;
        ar_write_en = 1'b1;
      end
      FETCH_MEM: mem_rd = 1'b1;
      FETCH_IR: begin
        bus_sel     = 3'd2;
        ir_write_en = 1'b1;
        pc_inc_en   = 1'b1;
      end
      DECODE:  dec_valid = !illegal && !is_halt;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, fetch timing, wait states,
// timeout, HALT and illegal-opcode behaviour.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_ready;
  logic [5:0]  opcode;
  logic        exec_done;
  logic [2:0]  bus_sel;
  logic        ar_write_en;
  logic        mem_rd;
  logic        ir_write_en;
  logic        pc_inc_en;
  logic        dec_valid;
  logic [5:0]  dec_opcode;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;
  logic [15:0] instr_count;
  logic [2:0]  state;

  int n_asrt = 0;
  int n_fail = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .mem_ready(mem_ready),
    .opcode(opcode), .exec_done(exec_done), .bus_sel(bus_sel),
    .ar_write_en(ar_write_en), .mem_rd(mem_rd),
    .ir_write_en(ir_write_en), .pc_inc_en(pc_inc_en),
    .dec_valid(dec_valid), .dec_opcode(dec_opcode), .halted(halted),
    .fault(fault), .fault_code(fault_code),
    .instr_count(instr_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strobes_off(input string tag);
    chk({tag, "_bus"}, 16'(bus_sel), 16'd0);
    chk({tag, "_ar"}, 16'(ar_write_en), 16'd0);
    chk({tag, "_rd"}, 16'(mem_rd), 16'd0);
    chk({tag, "_ir"}, 16'(ir_write_en), 16'd0);
    chk({tag, "_pc"}, 16'(pc_inc_en), 16'd0);
    chk({tag, "_dv"}, 16'(dec_valid), 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'($urandom);
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    exec_done = 1'($urandom);
    tick();
    start = 1'($urandom);
    mem_ready = 1'($urandom);
    opcode = 6'($urandom);
    exec_done = 1'($urandom);
    tick();
    #1;
    chk("rst_state", 16'(state), 16'd0);
    chk_strobes_off("rst");
    chk("rst_dop", 16'(dec_opcode), 16'd0);
    chk("rst_halt", 16'(halted), 16'd0);
    chk("rst_flt", 16'(fault), 16'd0);
    chk("rst_fc", 16'(fault_code), 16'd0);
    chk("rst_cnt", instr_count, 16'd0);

    // Basic fetch, minimum 5-cycle instruction
    rst = 1'b0; start = 1'b1; mem_ready = 1'b1;
    opcode = 6'h05; exec_done = 1'b1;
    tick(); start = 1'b0; #1;
    chk("b_s1", 16'(state), 16'd1);
    chk("b_bus1", 16'(bus_sel), 16'd1);
    chk("b_ar", 16'(ar_write_en), 16'd1);
    tick(); #1;
    chk("b_s2", 16'(state), 16'd2);
    chk("b_rd", 16'(mem_rd), 16'd1);
    tick(); #1;
    chk("b_s3", 16'(state), 16'd3);
    chk("b_bus2", 16'(bus_sel), 16'd2);
    chk("b_irpc", 16'({ir_write_en, pc_inc_en}), 16'd3);
    tick(); #1;
    chk("b_s4", 16'(state), 16'd4);
    chk("b_dv", 16'(dec_valid), 16'd1);
    tick(); #1;
    chk("b_s5", 16'(state), 16'd5);
    chk("b_dv_off", 16'(dec_valid), 16'd0);
    chk("b_dop", 16'(dec_opcode), 16'h05);
    chk("b_cnt0", instr_count, 16'd0);
    tick(); #1;
    chk("b_s1b", 16'(state), 16'd1);
    chk("b_cnt1", instr_count, 16'd1);

    // Wait states: mem_ready three cycles late
    mem_ready = 1'b0; exec_done = 1'b0; opcode = 6'h0A;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk($sformatf("w_rd%0d", i), 16'(mem_rd), 16'd1);
      chk($sformatf("w_ir%0d", i), 16'(ir_write_en), 16'd0);
    end
    tick(); mem_ready = 1'b0; #1;
    chk("w_s3", 16'(state), 16'd3);
    chk("w_rd_off", 16'(mem_rd), 16'd0);
    chk("w_irpc", 16'({ir_write_en, pc_inc_en}), 16'd3);
    tick(); #1;
    chk("w_irpc_off", 16'({ir_write_en, pc_inc_en}), 16'd0);
    chk("w_dv", 16'(dec_valid), 16'd1);
    tick(); tick(); tick(); #1;
    chk("w_hold_ex", 16'(state), 16'd5);
    chk("w_dv_once", 16'(dec_valid), 16'd0);
    chk("w_dop", 16'(dec_opcode), 16'h0A);

    // Reset mid-EXEC clears everything
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rx_state", 16'(state), 16'd0);
    chk("rx_cnt", instr_count, 16'd0);
    chk_strobes_off("rx");

    // HALT
    start = 1'b1; mem_ready = 1'b1; opcode = 6'h1F;
    tick(); start = 1'b0;
    tick(); tick(); tick(); #1;
    chk("h_s4", 16'(state), 16'd4);
    chk("h_dv", 16'(dec_valid), 16'd0);
    tick(); #1;
    chk("h_s0", 16'(state), 16'd0);
    chk("h_halt", 16'(halted), 16'd1);
    chk("h_cnt", instr_count, 16'd1);
    tick(); #1;
    chk("h_stay", 16'(state), 16'd0);
    start = 1'b1;
    tick(); start = 1'b0; #1;
    chk("h_restart", 16'(state), 16'd1);
    chk("h_clr", 16'(halted), 16'd0);

    // Illegal opcode from the restarted fetch
    opcode = 6'h20;
    tick(); tick(); tick(); #1;
    chk("il_s4", 16'(state), 16'd4);
    chk("il_dv", 16'(dec_valid), 16'd0);
    tick(); #1;
    chk("il_s7", 16'(state), 16'd7);
    chk("il_flt", 16'(fault), 16'd1);
    chk("il_fc", 16'(fault_code), 16'd2);
    chk("il_dop", 16'(dec_opcode), 16'h20);
    mem_ready = 1'b1; exec_done = 1'b1; start = 1'b1;
    tick(); #1;
    chk("il_hold", 16'(state), 16'd7);
    chk_strobes_off("il");
    chk("il_cnt", instr_count, 16'd1);

    // Timeout with mem_ready stuck low
    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; exec_done = 1'b0;
    opcode = 6'h05;
    tick(); rst = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(); #1;
      chk($sformatf("t_rd%0d", i), 16'(mem_rd), 16'd1);
    end
    tick(); #1;
    chk("t_s7", 16'(state), 16'd7);
    chk("t_flt", 16'(fault), 16'd1);
    chk("t_fc", 16'(fault_code), 16'd1);
    chk("t_rd_off", 16'(mem_rd), 16'd0);
    start = 1'b1;
    tick(); start = 1'b0; tick(); #1;
    chk("t_ign", 16'(state), 16'd7);

    // mem_ready on the final timeout cycle wins
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("tb_rst_flt", 16'(fault), 16'd0);
    start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (i == 14) mem_ready = 1'b1;
      #1;
    end
    tick(); mem_ready = 1'b0; #1;
    chk("tb_s3", 16'(state), 16'd3);
    chk("tb_flt", 16'(fault), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
